// File: rtl/alu_operand_stage.sv
// Execute-stage controller in front of the 16-bit ALU: decodes one instruction, owns rf and PSR, writes back in 3 cycles.
// Optional: REG_ZERO_HARDWIRE_EN makes r0 read as zero and discards writes to it.
module alu_operand_stage #(
  parameter int BIT_WIDTH    = 16,
  parameter int OPCODE_WIDTH = 8,
  parameter int FLAG_WIDTH   = 5,
  parameter int NUM_REGS     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             instr,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  output logic [BIT_WIDTH-1:0]    alu_rdest,
  output logic [BIT_WIDTH-1:0]    alu_rsrc_imm,
  output logic [OPCODE_WIDTH-1:0] alu_opcode,
  input  logic [BIT_WIDTH-1:0]    alu_result,
  input  logic [FLAG_WIDTH-1:0]   alu_flags,
  output logic                    wb_done,
  output logic [FLAG_WIDTH-1:0]   psr,
  output logic                    illegal,
  input  logic [3:0]              dbg_addr,
  output logic [BIT_WIDTH-1:0]    dbg_data
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t state, state_nxt;
  logic [15:0] ir;
  logic [NUM_REGS-1:0][BIT_WIDTH-1:0] rf, rf_view;
  logic [3:0] op, rd, ext, rs;
  logic [7:0] imm8, opc;
  logic legal, reg_form, sx_imm, zx_imm, sh_imm, is_nop, is_cmp, rf_we, psr_we;

  assign op   = ir[15:12];
  assign rd   = ir[11:8];
  assign ext  = ir[7:4];
  assign rs   = ir[3:0];
  assign imm8 = ir[7:0];
  assign opc  = {op, ext};

  always_comb begin
    legal    = 1'b0;
    reg_form = 1'b0;
    sx_imm   = 1'b0;
    zx_imm   = 1'b0;
    sh_imm   = 1'b0;
    case (op)
      4'h0: begin
        reg_form = 1'b1;
        legal    = (ext <= 4'h7) || (ext == 4'h9) || (ext == 4'hB);
      end
      4'h5, 4'h9, 4'hB: begin legal = 1'b1; sx_imm = 1'b1; end
      4'h6, 4'h7:       begin legal = 1'b1; zx_imm = 1'b1; end
      4'h8: begin
        case (ext)
          4'h0, 4'h1, 4'h2, 4'h3, 4'hA, 4'hB: begin legal = 1'b1; sh_imm = 1'b1; end
          4'h4, 4'h6, 4'h8, 4'h9:             begin legal = 1'b1; reg_form = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign is_nop = (opc == 8'h00);
  assign is_cmp = (opc == 8'h0B) || (op == 4'hB);
  assign psr_we = legal && !is_nop;

  // Zero-register variant: mask the read view and suppress the write enable.
  always_comb begin
    rf_view = rf;
    rf_we   = legal && !is_nop && !is_cmp;
`ifdef REG_ZERO_HARDWIRE_EN
    rf_view[0] = '0;
    if (rd == 4'd0) rf_we = 1'b0;
`endif
  end

  assign dbg_data    = rf_view[dbg_addr];
  assign instr_ready = (state == IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (instr_valid) state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are combinational from rf, so rd == rs sees the pre-write value.
  always_comb begin
    alu_opcode   = '0;
    alu_rdest    = '0;
    alu_rsrc_imm = '0;
    if (state == EXEC) begin
      alu_opcode = opc;
      alu_rdest  = rf_view[rd];
      if (reg_form)    alu_rsrc_imm = rf_view[rs];
      else if (sx_imm) alu_rsrc_imm = {{(BIT_WIDTH-8){imm8[7]}}, imm8};
      else if (zx_imm) alu_rsrc_imm = {{(BIT_WIDTH-8){1'b0}}, imm8};
      else if (sh_imm) alu_rsrc_imm = {{(BIT_WIDTH-4){1'b0}}, rs};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ir      <= '0;
      rf      <= '0;
      psr     <= '0;
      illegal <= 1'b0;
      wb_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      wb_done <= (state == EXEC);
      if (state == IDLE && instr_valid) ir <= instr;
      if (state == EXEC) begin
        if (rf_we)  rf[rd] <= alu_result;
        if (psr_we) psr    <= alu_flags;
        if (!legal) illegal <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed-vector bench for alu_operand_stage; the ALU is stood in for by hand-computed result/flag values.
module tb_alu_operand_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] alu_rdest, alu_rsrc_imm, alu_result, dbg_data;
  logic [7:0]  alu_opcode;
  logic [4:0]  alu_flags, psr;
  logic        wb_done, illegal;
  logic [3:0]  dbg_addr;
  int          n_vec = 0;
  int          n_err = 0;

`ifdef REG_ZERO_HARDWIRE_EN
  localparam bit R0_HW = 1'b1;
`else
  localparam bit R0_HW = 1'b0;
`endif

  alu_operand_stage dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_rdest(alu_rdest), .alu_rsrc_imm(alu_rsrc_imm),
    .alu_opcode(alu_opcode), .alu_result(alu_result), .alu_flags(alu_flags),
    .wb_done(wb_done), .psr(psr), .illegal(illegal), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd_dbg(input logic [3:0] a, input logic [15:0] exp, input string tag);
    dbg_addr = a;
    #1 chk(tag, dbg_data, exp);
  endtask

  // One full accept/EXEC/DONE/IDLE transaction with EXEC-cycle operand checks.
  task automatic run(input logic [15:0] i, input logic [15:0] res, input logic [4:0] fl,
                     input logic [7:0] e_op, input logic [15:0] e_rd, input logic [15:0] e_rs);
    @(negedge clk);
    instr = i; instr_valid = 1'b1; alu_result = res; alu_flags = fl;
    chk("ready_idle", instr_ready, 1);
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = 16'h0000;
    chk("exec_opcode", alu_opcode, e_op);
    chk("exec_rdest", alu_rdest, e_rd);
    chk("exec_rsrc", alu_rsrc_imm, e_rs);
    chk("exec_ready", instr_ready, 0);
    chk("exec_wb", wb_done, 0);
    @(posedge clk); #1;
    chk("done_wb", wb_done, 1);
    chk("done_ready", instr_ready, 0);
    chk("done_opcode", alu_opcode, 0);
    @(posedge clk); #1;
    chk("idle_wb", wb_done, 0);
    chk("idle_ready", instr_ready, 1);
  endtask

  initial begin
    reset = 1'b1; instr = '0; instr_valid = 1'b0; alu_result = '0; alu_flags = '0; dbg_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", instr_ready, 1);
    chk("rst_opcode", alu_opcode, 0);
    chk("rst_rdest", alu_rdest, 0);
    chk("rst_rsrc", alu_rsrc_imm, 0);
    chk("rst_wb", wb_done, 0);
    chk("rst_psr", psr, 0);
    chk("rst_illegal", illegal, 0);
    @(negedge clk); reset = 1'b0;
    rd_dbg(4'd1, 16'h0000, "rst_r1");

    // ADDI r1,5
    run(16'h5105, 16'h0005, 5'b00000, 8'h50, 16'h0000, 16'h0005);
    rd_dbg(4'd1, 16'h0005, "addi_r1");
    // ADDI r2,-3 (sign-extended)
    run(16'h52FD, 16'hFFFD, 5'b00001, 8'h5F, 16'h0000, 16'hFFFD);
    rd_dbg(4'd2, 16'hFFFD, "addi_r2");
    chk("addi_psr", psr, 5'b00001);
    // ADD r1,r2
    run(16'h0152, 16'h0002, 5'b00000, 8'h05, 16'h0005, 16'hFFFD);
    rd_dbg(4'd1, 16'h0002, "add_r1");
    chk("add_psr_c", psr[4], 0);
    // CMP r1,r2: flags only
    run(16'h01B2, 16'h1234, 5'b10010, 8'h0B, 16'h0002, 16'hFFFD);
    rd_dbg(4'd1, 16'h0002, "cmp_r1_kept");
    chk("cmp_psr", psr, 5'b10010);
    // ADDUI r3,0xFF (zero-extended)
    run(16'h63FF, 16'h00FF, 5'b00000, 8'h6F, 16'h0000, 16'h00FF);
    rd_dbg(4'd3, 16'h00FF, "addui_r3");
    // LSHI r3,4
    run(16'h8304, 16'h0FF0, 5'b00000, 8'h80, 16'h00FF, 16'h0004);
    rd_dbg(4'd3, 16'h0FF0, "lshi_r3");
    // ADDCI r4,0x80 zero-extends; SUBI r4,0x80 sign-extends
    run(16'h7480, 16'h0080, 5'b00000, 8'h78, 16'h0000, 16'h0080);
    run(16'h9480, 16'h0100, 5'b00100, 8'h98, 16'h0080, 16'hFF80);
    rd_dbg(4'd4, 16'h0100, "subi_r4");
    // CMPI r4,-1: no rf write
    run(16'hB4FF, 16'hAAAA, 5'b01000, 8'hBF, 16'h0100, 16'hFFFF);
    rd_dbg(4'd4, 16'h0100, "cmpi_r4_kept");
    chk("cmpi_psr", psr, 5'b01000);
    // LSH register form r4 by r1
    run(16'h8441, 16'h0400, 5'b00000, 8'h84, 16'h0100, 16'h0002);
    rd_dbg(4'd4, 16'h0400, "lsh_r4");

    // NOP touches nothing
    run(16'h0000, 16'h5555, 5'b11111, 8'h00, 16'h0000, 16'h0000);
    chk("nop_psr", psr, 5'b00000);
    rd_dbg(4'd0, 16'h0000, "nop_r0");

    // Illegal 0xF0
    run(16'hF000, 16'hBEEF, 5'b11111, 8'hF0, 16'h0000, 16'h0000);
    chk("ill_flag", illegal, 1);
    chk("ill_psr", psr, 5'b00000);
    rd_dbg(4'd0, 16'h0000, "ill_r0");
    // Illegal 0x85 into r1; illegal stays sticky
    run(16'h8151, 16'hBEEF, 5'b11111, 8'h85, 16'h0002, 16'h0000);
    rd_dbg(4'd1, 16'h0002, "ill85_r1");
    run(16'h5201, 16'h0001, 5'b00000, 8'h50, 16'hFFFD, 16'h0001);
    chk("ill_sticky", illegal, 1);

    // Reset during EXEC of ADDI r1,7
    @(negedge clk);
    instr = 16'h5107; instr_valid = 1'b1; alu_result = 16'h0007; alu_flags = 5'b00010;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("rx_opcode", alu_opcode, 8'h50);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chk("rx_ready", instr_ready, 1);
    chk("rx_illegal", illegal, 0);
    chk("rx_wb", wb_done, 0);
    chk("rx_psr", psr, 0);
    rd_dbg(4'd1, 16'h0000, "rx_r1");
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("rx_wb_after", wb_done, 0);

    // r0 behaviour, and rd == rs reading the pre-write value
    run(16'h5007, 16'h0007, 5'b00000, 8'h50, 16'h0000, 16'h0007);
    rd_dbg(4'd0, R0_HW ? 16'h0000 : 16'h0007, "r0_addi");
    run(16'h0050, 16'h000E, 5'b00000, 8'h05,
        R0_HW ? 16'h0000 : 16'h0007, R0_HW ? 16'h0000 : 16'h0007);
    rd_dbg(4'd0, R0_HW ? 16'h0000 : 16'h000E, "r0_add_self");

    // instr_valid ignored outside IDLE: held valid for a whole transaction
    @(negedge clk);
    instr = 16'h5603; instr_valid = 1'b1; alu_result = 16'h0003; alu_flags = 5'b00000;
    @(posedge clk); #1;
    instr = 16'h5609;
    @(posedge clk); #1;
    chk("hold_done_wb", wb_done, 1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    rd_dbg(4'd6, 16'h0003, "hold_r6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
